// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the C stage and the multi-cycle mul/div sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            Start_C;
  logic [2:0]      MulDivOp_C;
  logic [XLEN-1:0] OperandA_C;
  logic [XLEN-1:0] OperandB_C;
  logic            Flush_C;
  logic            Stall_C;
  logic            Busy;
  logic            Done_C;
  logic [XLEN-1:0] Result_C;

  modport master (
    output Start_C, MulDivOp_C, OperandA_C, OperandB_C, Flush_C,
    input  Stall_C, Busy, Done_C, Result_C
  );

  modport slave (
    input  Start_C, MulDivOp_C, OperandA_C, OperandB_C, Flush_C,
    output Stall_C, Busy, Done_C, Result_C
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV M-extension sequencer: shift-add multiplier and restoring divider, one bit per cycle,
// with divide-by-zero and signed-overflow results produced without iterating.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PREP  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] FIXUP = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opA_q, opA_d;
  logic [XLEN-1:0] opB_q, opB_d;
  logic [XLEN-1:0] accHi_q, accHi_d;
  logic [XLEN-1:0] accLo_q, accLo_d;
  logic [XLEN-1:0] bMag_q, bMag_d;
  logic            negQ_q, negQ_d;
  logic            negR_q, negR_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            start, flush;
  logic            divByZero, overflow, special;
  logic [XLEN-1:0] specialResult;
  logic            aSigned, bSigned, signA, signB;
  logic [XLEN-1:0] magA, magB;
  logic [XLEN:0]   mulSum, remShift, divDiff;
  logic            divFits;
  logic [2*XLEN-1:0] product, prodFix;
  logic [XLEN-1:0] quotFix, remFix;

  assign start = bus.Start_C;
  assign flush = bus.Flush_C;

  // Special cases are decided on the live operands so they can skip straight to DONE.
  assign divByZero = bus.MulDivOp_C[2] && (bus.OperandB_C == '0);
  assign overflow  = ((bus.MulDivOp_C == OP_DIV) || (bus.MulDivOp_C == OP_REM)) &&
                     (bus.OperandA_C == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.OperandB_C == '1);
  assign special   = divByZero || overflow;

  always_comb begin
    specialResult = '0;
    if (divByZero)
      specialResult = bus.MulDivOp_C[1] ? bus.OperandA_C : '1;
    else if (overflow)
      specialResult = bus.MulDivOp_C[1] ? '0 : bus.OperandA_C;
  end

  assign aSigned = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                   (op_q == OP_DIV) || (op_q == OP_REM);
  assign bSigned = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                   (op_q == OP_DIV) || (op_q == OP_REM);
  assign signA   = aSigned && opA_q[XLEN-1];
  assign signB   = bSigned && opB_q[XLEN-1];
  assign magA    = signA ? -opA_q : opA_q;
  assign magB    = signB ? -opB_q : opB_q;

  // accHi holds the running product high half / partial remainder; accLo the multiplier / quotient.
  assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, bMag_q} : '0);
  assign remShift = {accHi_q, accLo_q[XLEN-1]};
  assign divFits  = remShift >= {1'b0, bMag_q};
  assign divDiff  = remShift - {1'b0, bMag_q};

  assign product = {accHi_q, accLo_q};
  assign prodFix = negQ_q ? -product : product;
  assign quotFix = negQ_q ? -accLo_q : accLo_q;
  assign remFix  = negR_q ? -accHi_q : accHi_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    accHi_d  = accHi_q;
    accLo_d  = accLo_q;
    bMag_d   = bMag_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = bus.MulDivOp_C;
          opA_d = bus.OperandA_C;
          opB_d = bus.OperandB_C;
          if (special) begin
            result_d = specialResult;
            state_d  = DONE;
          end else begin
            state_d  = PREP;
          end
        end
      end
      PREP: begin
        accHi_d = '0;
        accLo_d = magA;
        bMag_d  = magB;
        negQ_d  = signA ^ signB;
        negR_d  = signA;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (op_q[2]) begin
          accHi_d = divFits ? divDiff[XLEN-1:0] : remShift[XLEN-1:0];
          accLo_d = {accLo_q[XLEN-2:0], divFits};
        end else begin
          accHi_d = mulSum[XLEN:1];
          accLo_d = {mulSum[0], accLo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1))
          state_d = FIXUP;
      end
      FIXUP: begin
        case (op_q)
          OP_MUL:                        result_d = prodFix[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prodFix[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:               result_d = quotFix;
          default:                       result_d = remFix;
        endcase
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A squashed instruction abandons whatever is in flight.
    if (flush && (state_q != IDLE))
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      accHi_q  <= '0;
      accLo_q  <= '0;
      bMag_q   <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      accHi_q  <= accHi_d;
      accLo_q  <= accLo_d;
      bMag_q   <= bMag_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Stall is combinational on Start_C so the issuing instruction cannot slip past C.
  assign bus.Stall_C  = reset && !flush &&
                        (((state_q == IDLE) && start) ||
                         (state_q == PREP) || (state_q == RUN) || (state_q == FIXUP));
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done_C   = (state_q == DONE) && !flush;
  assign bus.Result_C = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops against
// a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic clk;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;
  int   doneCount  = 0;
  time  lastDoneTime;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle in which a result is presented.
  always @(negedge clk) begin
    if (bus.Done_C === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // RISC-V M-extension semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op starting #1 after a rising edge with the sequencer idle; checks
  // latency, stall cycles and result. Leaves Start_C high through DONE if holdStart.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit holdStart);
    int latency, stallCycles, expLatency;
    logic special;
    special = (op[2] && b == 0) ||
              ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    expLatency = special ? 1 : XLEN + 3;
    bus.Start_C    = 1'b1;
    bus.MulDivOp_C = op;
    bus.OperandA_C = a;
    bus.OperandB_C = b;
    latency = 0;
    stallCycles = 0;
    #1;
    if (bus.Stall_C === 1'b1) stallCycles++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.Done_C === 1'b1) begin
        latency = k;
        lastDoneTime = $time;
        break;
      end
      if (bus.Stall_C === 1'b1) stallCycles++;
    end
    checkOutput("latency", 64'(latency), 64'(expLatency));
    checkOutput("stallCycles", 64'(stallCycles), 64'(expLatency));
    checkOutput($sformatf("result op%0d a=%0h b=%0h", op, a, b), 64'(bus.Result_C),
                64'(refModel(op, a, b)));
    if (!holdStart) begin
      bus.Start_C = 1'b0;
      @(posedge clk); #1;
      checkOutput("idleBusy", 64'(bus.Busy), 64'd0);
    end
  endtask

  initial begin
    int   doneBefore;
    time  firstDone;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset          = 1'b0;
    bus.Start_C    = 1'b0;
    bus.MulDivOp_C = '0;
    bus.OperandA_C = '0;
    bus.OperandB_C = '0;
    bus.Flush_C    = 1'b0;
    #3;
    checkOutput("rstBusy", 64'(bus.Busy), 64'd0);
    checkOutput("rstStall", 64'(bus.Stall_C), 64'd0);
    checkOutput("rstDone", 64'(bus.Done_C), 64'd0);
    checkOutput("rstResult", 64'(bus.Result_C), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus(3'd5, 32'd100, 32'd7, 1'b0);
    applyStimulus(3'd7, 32'd100, 32'd7, 1'b0);
    applyStimulus(3'd5, 32'h1234, 32'd0, 1'b0);
    applyStimulus(3'd7, 32'h1234, 32'd0, 1'b0);
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush at RUN counter 10 (cycle t+12).
    doneBefore     = doneCount;
    bus.Start_C    = 1'b1;
    bus.MulDivOp_C = 3'd5;
    bus.OperandA_C = 32'd1000;
    bus.OperandB_C = 32'd3;
    repeat (12) begin @(posedge clk); #1; end
    bus.Flush_C = 1'b1;
    bus.Start_C = 1'b0;
    #1;
    checkOutput("flushStall", 64'(bus.Stall_C), 64'd0);
    checkOutput("flushDone", 64'(bus.Done_C), 64'd0);
    @(posedge clk); #1;
    bus.Flush_C = 1'b0;
    checkOutput("flushIdle", 64'(bus.Busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("flushNoDone", 64'(doneCount - doneBefore), 64'd0);

    // Reset at RUN counter 5 (cycle t+7).
    bus.Start_C    = 1'b1;
    bus.MulDivOp_C = 3'd4;
    bus.OperandA_C = 32'd12345;
    bus.OperandB_C = 32'd17;
    repeat (7) begin @(posedge clk); #1; end
    reset       = 1'b0;
    bus.Start_C = 1'b0;
    #1;
    checkOutput("midRstBusy", 64'(bus.Busy), 64'd0);
    checkOutput("midRstStall", 64'(bus.Stall_C), 64'd0);
    checkOutput("midRstDone", 64'(bus.Done_C), 64'd0);
    checkOutput("midRstResult", 64'(bus.Result_C), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(3'd5, 32'd9, 32'd3, 1'b0);

    // Back-to-back MULs: Start_C held through DONE, next op issued in the following IDLE cycle.
    doneBefore = doneCount;
    applyStimulus(3'd0, 32'd123, 32'd456, 1'b1);
    firstDone = lastDoneTime;
    @(posedge clk); #1;
    applyStimulus(3'd0, 32'hDEAD, 32'hBEEF, 1'b0);
    checkOutput("b2bSpacing", 64'(lastDoneTime - firstDone), 64'd360);
    checkOutput("b2bPulses", 64'(doneCount - doneBefore), 64'd2);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       begin ra = $urandom; rb = 32'd0; end
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       begin ra = 32'($signed(12'($urandom))); rb = 32'($signed(6'($urandom))); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      applyStimulus(rop, ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
